tc_timer: RTL and testbench

- Memory-mapped timer/counter peripheral that sits directly downstream of the CPU's peripheral bus (pr_we / pr_a / pr_wd / pr_rd) through the system bridge.
- Its interrupt output feeds one bit of the CPU's hwint[5:0].
- Software programs a preset value, enables it, and receives an interrupt on expiry.
- Two modes: one-shot (level interrupt held until software acknowledges) and auto-reload (one-cycle interrupt pulse per period).

---
 rtl/tc_timer.sv | 147 ++++++++++++++
 tb/tb_tc_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped timer/counter with one-shot and auto-reload modes.
// Register map (word address):
//   0 CTRL   R/W  bit0 EN, bits[2:1] MODE (1 = auto-reload, others one-shot), bit3 IM
//   1 PRESET R/W
//   2 COUNT  RO
//   3 reads 0, writes ignored
module tc_timer #(
    parameter logic [31:0] PRESET_RST = 32'd0,
    parameter logic [31:0] CTRL_MASK  = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned EN_BIT = 0;
    localparam int unsigned IM_BIT = 3;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PRESET = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(2);

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   preset_q, preset_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic                flag_q, flag_d;

    logic                en;
    logic                im;
    logic                mode_reload;
    logic                ctrl_wr;
    logic                preset_wr;

    // Field decode of the registered control word
    always_comb begin
        en          = ctrl_q[EN_BIT];
        im          = ctrl_q[IM_BIT];
        mode_reload = (ctrl_q[2:1] == MODE_RELOAD);
        ctrl_wr     = we && (addr == A_CTRL);
        preset_wr   = we && (addr == A_PRESET);
    end

    // Next-state: FSM first, then bus writes so software always wins a collision
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (en) begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > DATA_W'(1)) begin
                    count_d = count_q - DATA_W'(1);
                end else begin
                    // Covers PRESET = 0 as well: clamp at zero, never wrap
                    count_d = '0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (mode_reload) begin
                    state_d = en ? ST_LOAD : ST_IDLE;
                end else begin
                    flag_d         = 1'b1;
                    ctrl_d[EN_BIT] = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (preset_wr) begin
            preset_d = wd;
        end
        if (ctrl_wr) begin
            ctrl_d = wd & CTRL_MASK;
            flag_d = 1'b0;
        end
    end

    // State and register bank, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= PRESET_RST;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Read mux, combinational from addr
    always_comb begin
        case (addr)
            A_CTRL:   rd = ctrl_q;
            A_PRESET: rd = preset_q;
            A_COUNT:  rd = count_q;
            default:  rd = '0;
        endcase
    end

    // Interrupt: held flag in one-shot, single INT-cycle pulse in auto-reload
    always_comb begin
        irq = im & (mode_reload ? (state_q == ST_INT) : flag_q);
    end

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares rd/irq.
module tb_tc_timer;

    localparam logic [31:0] PR = 32'h0000_0007;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    tc_timer #(
        .PRESET_RST(PR),
        .CTRL_MASK (32'h0000_000F)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    typedef struct {
        int          cyc;
        logic [31:0] erd;
        logic        eirq;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    cyc   = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    // Hand-computed COUNT sequences, one entry per cycle after the CTRL write edge
    logic [31:0] os_cnt [8]  = '{0, 0, 5, 4, 3, 2, 1, 0};
    logic [31:0] ar_cnt [22] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0,
                                 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    logic [21:0] ar_irq      = 22'h108420;
    logic [31:0] mk_cnt [6]  = '{0, 0, 2, 1, 0, 0};
    logic [31:0] mp_cnt [15] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 2, 1, 0, 0, 2};
    logic [14:0] mp_irq      = 15'h1100;
    logic [6:0]  p0_irq      = 7'h48;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || rd !== e.erd || irq !== e.eirq) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: rd=%h irq=%b, expected rd=%h irq=%b",
                         nm, cyc, rd, irq, e.erd, e.eirq);
            end
        end
    end

    task automatic tick(input logic rst, input logic w, input logic [1:0] a,
                        input logic [31:0] d, input logic [31:0] erd,
                        input logic eirq, input string nm);
        exp_t e;
        reset = rst;
        we    = w;
        addr  = a;
        wd    = d;
        e.cyc  = cyc;
        e.erd  = erd;
        e.eirq = eirq;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic rdc(input logic [1:0] a, input logic [31:0] erd,
                       input logic eirq, input string nm);
        tick(1'b0, 1'b0, a, 32'd0, erd, eirq, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] erd, input logic eirq, input string nm);
        tick(1'b0, 1'b1, a, d, erd, eirq, nm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values, read-only COUNT, dead addr 3, CTRL mask
        rdc(2'd0, 32'd0, 1'b0, "rst_ctrl");
        rdc(2'd1, PR,    1'b0, "rst_preset");
        rdc(2'd2, 32'd0, 1'b0, "rst_count");
        rdc(2'd3, 32'd0, 1'b0, "rst_addr3");
        wr (2'd2, 32'h55, 32'd0, 1'b0, "count_wr");
        wr (2'd3, 32'h66, 32'd0, 1'b0, "addr3_wr");
        rdc(2'd2, 32'd0, 1'b0, "count_ro");
        rdc(2'd3, 32'd0, 1'b0, "addr3_ro");
        wr (2'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, "ctrl_wr_all");
        wr (2'd0, 32'd0, 32'h0000_000F, 1'b0, "ctrl_mask");

        // One-shot, PRESET = 5, IM = 1
        do_reset();
        wr(2'd1, 32'd5, PR, 1'b0, "os_preset");
        wr(2'd0, 32'h9, 32'd0, 1'b0, "os_ctrl");
        for (int i = 0; i < 8; i++) rdc(2'd2, os_cnt[i], 1'b0, "os_count");
        rdc(2'd0, 32'h8, 1'b1, "os_irq_ctrl");
        rdc(2'd2, 32'd0, 1'b1, "os_irq_hold");
        wr (2'd0, 32'd0, 32'h8, 1'b1, "os_ack");
        rdc(2'd0, 32'd0, 1'b0, "os_irq_low");

        // Auto-reload, PRESET = 3: pulse every 5 cycles, EN kept
        do_reset();
        wr(2'd1, 32'd3, PR, 1'b0, "ar_preset");
        wr(2'd0, 32'hB, 32'd0, 1'b0, "ar_ctrl");
        for (int i = 0; i < 22; i++) rdc(2'd2, ar_cnt[i], ar_irq[i], "ar_count");
        rdc(2'd0, 32'hB, 1'b0, "ar_en_kept");

        // Masked one-shot: no irq, EN self-clears, COUNT ends at 0
        do_reset();
        wr(2'd1, 32'd2, PR, 1'b0, "mk_preset");
        wr(2'd0, 32'h1, 32'd0, 1'b0, "mk_ctrl");
        for (int i = 0; i < 6; i++) rdc(2'd2, mk_cnt[i], 1'b0, "mk_count");
        rdc(2'd0, 32'd0, 1'b0, "mk_en_clr");
        rdc(2'd2, 32'd0, 1'b0, "mk_count_end");

        // PRESET rewritten mid-count: current run from 10, next reload from 2
        do_reset();
        wr (2'd1, 32'd10, PR, 1'b0, "mp_preset");
        wr (2'd0, 32'hB, 32'd0, 1'b0, "mp_ctrl");
        rdc(2'd2, 32'd0,  1'b0, "mp_idle");
        rdc(2'd2, 32'd0,  1'b0, "mp_load");
        rdc(2'd2, 32'd10, 1'b0, "mp_first");
        wr (2'd1, 32'd2, 32'd10, 1'b0, "mp_preset_wr");
        for (int i = 0; i < 15; i++) rdc(2'd2, mp_cnt[i], mp_irq[i], "mp_count");

        // Clear EN at COUNT = 6, re-enable reloads, then reset mid-count
        do_reset();
        wr (2'd1, 32'd10, PR, 1'b0, "ec_preset");
        wr (2'd0, 32'h9, 32'd0, 1'b0, "ec_ctrl");
        rdc(2'd2, 32'd0,  1'b0, "ec_c0");
        rdc(2'd2, 32'd0,  1'b0, "ec_c1");
        rdc(2'd2, 32'd10, 1'b0, "ec_c2");
        rdc(2'd2, 32'd9,  1'b0, "ec_c3");
        rdc(2'd2, 32'd8,  1'b0, "ec_c4");
        wr (2'd0, 32'h8, 32'h9, 1'b0, "ec_clear");
        rdc(2'd2, 32'd6,  1'b0, "ec_frozen0");
        rdc(2'd2, 32'd6,  1'b0, "ec_frozen1");
        rdc(2'd2, 32'd6,  1'b0, "ec_frozen2");
        rdc(2'd0, 32'h8,  1'b0, "ec_ctrl_rd");
        wr (2'd0, 32'h9, 32'h8, 1'b0, "ec_reen");
        rdc(2'd2, 32'd6,  1'b0, "ec_re_idle");
        rdc(2'd2, 32'd6,  1'b0, "ec_re_load");
        rdc(2'd2, 32'd10, 1'b0, "ec_reload");
        rdc(2'd2, 32'd9,  1'b0, "ec_recount");
        tick(1'b1, 1'b0, 2'd2, 32'd0, 32'd8, 1'b0, "rs_before");
        rdc(2'd2, 32'd0, 1'b0, "rs_count");
        rdc(2'd0, 32'd0, 1'b0, "rs_ctrl");
        rdc(2'd1, PR,    1'b0, "rs_preset");

        // CTRL write on the one-shot INT cycle: write wins, restart via IDLE->LOAD
        do_reset();
        wr (2'd1, 32'd2, PR, 1'b0, "co_preset");
        wr (2'd0, 32'h9, 32'd0, 1'b0, "co_ctrl");
        rdc(2'd2, 32'd0, 1'b0, "co_c0");
        rdc(2'd2, 32'd0, 1'b0, "co_c1");
        rdc(2'd2, 32'd2, 1'b0, "co_c2");
        rdc(2'd2, 32'd1, 1'b0, "co_c3");
        wr (2'd0, 32'h9, 32'h9, 1'b0, "co_int_wr");
        rdc(2'd0, 32'h9, 1'b0, "co_en_kept");
        rdc(2'd2, 32'd0, 1'b0, "co_reload");
        rdc(2'd2, 32'd2, 1'b0, "co_cnt2");
        rdc(2'd2, 32'd1, 1'b0, "co_cnt1");
        rdc(2'd2, 32'd0, 1'b0, "co_int2");
        rdc(2'd0, 32'h8, 1'b1, "co_irq2");

        // PRESET = 0 auto-reload: one CNT cycle, period 3
        do_reset();
        wr(2'd1, 32'd0, PR, 1'b0, "p0_preset");
        wr(2'd0, 32'hB, 32'd0, 1'b0, "p0_ctrl");
        for (int i = 0; i < 7; i++) rdc(2'd2, 32'd0, p0_irq[i], "p0_count");

        do_reset();
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hang guard
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
